ksa_add_pipe: RTL

- Pipelined Kogge-Stone adder computing o_s = i_a + i_b + i_c0. It is the addition counterpart of the team's combinational ksa_sub.
- Sits in the RISC CPU execute path, feeding the ALU result mux and the address-generation unit.
- Uses a valid/ready handshake on both sides and splits the prefix tree over 3 register stages so the adder meets timing at full clock rate.

---
 rtl/ksa_add_pipe.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ksa_add_pipe.sv
// ksa_add_pipe: pipelined Kogge-Stone adder, o_s = i_a + i_b + i_c0.
//
// The prefix tree is split over three register stages:
//   S1  bitwise propagate/generate (carry-in folded into bit-0 generate)
//   S2  group (G,P) after the first ceil(L/2) prefix levels, L = log2(WIDTH)
//   S3  remaining prefix levels, sum, carry-out and signed overflow
// Each stage has a valid bit. A stage loads whenever it may advance, so
// empty stages (bubbles) are filled even while the output is stalled.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    operand handshake (o_ready is combinational from i_ready)
//   i_a, i_b, i_c0       operands and carry-in
//   o_valid / i_ready    result handshake
//   o_s                  sum modulo 2^WIDTH
//   o_carry              unsigned carry-out
//   o_ovf                signed overflow
//
// WIDTH must be a power of two in the range 8..64.

module ksa_add_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_c0,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int L  = $clog2(WIDTH);
    localparam int L1 = (L + 1) / 2;

    // stage valid bits
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic adv1, adv2, adv3;

    // S1 data
    logic [WIDTH-1:0] p1_q, p1_d, g1_q, g1_d;
    logic             c01_q, c01_d, am1_q, am1_d, bm1_q, bm1_d;

    // S2 data
    logic [WIDTH-1:0] gg2_q, gg2_d, pp2_q, pp2_d, p2_q, p2_d;
    logic             c02_q, c02_d, am2_q, am2_d, bm2_q, bm2_d;

    // S3 data (the outputs)
    logic [WIDTH-1:0] s3_q, s3_d;
    logic             carry3_q, carry3_d, ovf3_q, ovf3_d;

    // prefix results feeding S2 and S3
    logic [WIDTH-1:0] pre_g2, pre_p2, carry_vec;

    // stage advance chain
    always_comb begin
        adv3 = ~v3_q | i_ready;
        adv2 = ~v2_q | adv3;
        adv1 = ~v1_q | adv2;
    end

    assign o_ready = adv1;
    assign o_valid = v3_q;
    assign o_s     = s3_q;
    assign o_carry = carry3_q;
    assign o_ovf   = ovf3_q;

    // S1: propagate/generate, carry-in merged into bit 0 so the tree needs no
    // separate carry-in input
    always_comb begin
        v1_d  = v1_q;
        p1_d  = p1_q;
        g1_d  = g1_q;
        c01_d = c01_q;
        am1_d = am1_q;
        bm1_d = bm1_q;
        if (adv1) begin
            v1_d = i_valid;
            if (i_valid) begin
                p1_d    = i_a ^ i_b;
                g1_d    = i_a & i_b;
                g1_d[0] = (i_a[0] & i_b[0]) | ((i_a[0] ^ i_b[0]) & i_c0);
                c01_d   = i_c0;
                am1_d   = i_a[WIDTH-1];
                bm1_d   = i_b[WIDTH-1];
            end
        end
    end

    // prefix levels 0..L1-1 (span 1, 2, 4, ...)
    always_comb begin : prefix_lo
        logic [WIDTH-1:0] gk, pk, gn, pn;
        gk = g1_q;
        pk = p1_q;
        gn = g1_q;
        pn = p1_q;
        for (int k = 0; k < L1; k++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    gn[i] = gk[i] | (pk[i] & gk[i - (1 << k)]);
                    pn[i] = pk[i] & pk[i - (1 << k)];
                end
            end
            gk = gn;
            pk = pn;
        end
        pre_g2 = gk;
        pre_p2 = pk;
    end

    // S2
    always_comb begin
        v2_d  = v2_q;
        gg2_d = gg2_q;
        pp2_d = pp2_q;
        p2_d  = p2_q;
        c02_d = c02_q;
        am2_d = am2_q;
        bm2_d = bm2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                gg2_d = pre_g2;
                pp2_d = pre_p2;
                p2_d  = p1_q;
                c02_d = c01_q;
                am2_d = am1_q;
                bm2_d = bm1_q;
            end
        end
    end

    // prefix levels L1..L-1; afterwards carry_vec[i] is the carry out of bit i
    always_comb begin : prefix_hi
        logic [WIDTH-1:0] gk, pk, gn, pn;
        gk = gg2_q;
        pk = pp2_q;
        gn = gg2_q;
        pn = pp2_q;
        for (int k = L1; k < L; k++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << k)) begin
                    gn[i] = gk[i] | (pk[i] & gk[i - (1 << k)]);
                    pn[i] = pk[i] & pk[i - (1 << k)];
                end
            end
            gk = gn;
            pk = pn;
        end
        carry_vec = gk;
    end

    // S3: sum bit i uses the carry out of bit i-1; bit 0 uses the carry-in
    always_comb begin
        logic [WIDTH-1:0] sum;
        sum      = p2_q ^ {carry_vec[WIDTH-2:0], c02_q};
        v3_d     = v3_q;
        s3_d     = s3_q;
        carry3_d = carry3_q;
        ovf3_d   = ovf3_q;
        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                s3_d     = sum;
                carry3_d = carry_vec[WIDTH-1];
                ovf3_d   = (am2_q == bm2_q) && (sum[WIDTH-1] != am2_q);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            s3_q     <= '0;
            carry3_q <= 1'b0;
            ovf3_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            s3_q     <= s3_d;
            carry3_q <= carry3_d;
            ovf3_q   <= ovf3_d;
        end
    end

    // internal data is qualified by the valid bits, so it needs no reset
    always_ff @(posedge i_clk) begin
        p1_q  <= p1_d;
        g1_q  <= g1_d;
        c01_q <= c01_d;
        am1_q <= am1_d;
        bm1_q <= bm1_d;
        gg2_q <= gg2_d;
        pp2_q <= pp2_d;
        p2_q  <= p2_d;
        c02_q <= c02_d;
        am2_q <= am2_d;
        bm2_q <= bm2_d;
    end

endmodule
